// File: rtl/sync_event_pkg.sv
// sync_event_pkg: shared mode encodings and width helper for the multi-channel event detector
package sync_event_pkg;

    typedef enum logic [1:0] {
        MODE_OFF  = 2'b00,
        MODE_RISE = 2'b01,
        MODE_FALL = 2'b10,
        MODE_BOTH = 2'b11
    } mode_e;

    // Bits needed to represent values 0..n-1; used for the warm-up counter width.
    function automatic int clog2(input int n);
        int r;
        r = 0;
        while ((1 << r) < n) r++;
        return r;
    endfunction

endpackage

// File: rtl/sync_event_ch.sv
// sync_event_ch: one channel -- synchronizer chain, history flop, edge detector, sticky flag, saturating counter
//   clk, rst_n : clock, asynchronous active-low reset
//   i_async    : asynchronous input level
//   i_mode     : detection mode (off / rise / fall / both)
//   i_clr      : synchronous clear of sticky flag and counter
//   i_ready    : warm-up done; events are masked until high
//   o_sync     : synchronized level
//   o_pulse    : registered single-cycle event pulse
//   o_sticky   : sticky event flag
//   o_cnt      : saturating event count
module sync_event_ch
    import sync_event_pkg::*;
#(
    parameter int STAGES = 2,
    parameter int CNT_W  = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             i_async,
    input  logic [1:0]       i_mode,
    input  logic             i_clr,
    input  logic             i_ready,
    output logic             o_sync,
    output logic             o_pulse,
    output logic             o_sticky,
    output logic [CNT_W-1:0] o_cnt
);

    logic [STAGES-1:0] r_sync;
    logic              r_hist;
    logic              r_pulse;
    logic              r_sticky;
    logic [CNT_W-1:0]  r_cnt;

    logic              w_last;
    logic              w_rise;
    logic              w_fall;
    logic              w_det;
    logic              w_q;
    logic [CNT_W-1:0]  w_cnt_nxt;

    assign w_last = r_sync[STAGES-1];
    assign w_rise = w_last & ~r_hist;
    assign w_fall = ~w_last & r_hist;
    assign w_det  = (i_mode == MODE_RISE) ? w_rise :
                    (i_mode == MODE_FALL) ? w_fall :
                    (i_mode == MODE_BOTH) ? (w_rise | w_fall) : 1'b0;
    assign w_q    = w_det & i_ready;

    // A clear coinciding with an event restarts the count at 1 so the event is kept.
    assign w_cnt_nxt = i_clr ? (w_q ? CNT_W'(1) : '0) :
                       (w_q && (r_cnt != '1)) ? r_cnt + CNT_W'(1) : r_cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sync   <= '0;
            r_hist   <= 1'b0;
            r_pulse  <= 1'b0;
            r_sticky <= 1'b0;
            r_cnt    <= '0;
        end else begin
            r_sync   <= {r_sync[STAGES-2:0], i_async};
            r_hist   <= w_last;
            r_pulse  <= w_q;
            r_sticky <= w_q | (r_sticky & ~i_clr);
            r_cnt    <= w_cnt_nxt;
        end
    end

    assign o_sync   = w_last;
    assign o_pulse  = r_pulse;
    assign o_sticky = r_sticky;
    assign o_cnt    = r_cnt;

endmodule

// File: rtl/sync_event_detector.sv
// sync_event_detector: multi-channel asynchronous-input synchronizer with per-channel edge events
//   clk, rst_n       : clock, asynchronous active-low reset
//   i_async_in       : asynchronous input levels, one per channel
//   i_mode           : 2 bits per channel selecting off / rise / fall / both
//   i_clr            : per-channel synchronous clear of sticky flag and counter
//   o_sync_out       : synchronized levels
//   o_event_pulse    : single-cycle event pulses
//   o_event_sticky   : sticky event flags
//   o_event_cnt      : packed saturating counters, CNT_W bits per channel
//   o_ready          : warm-up completed
module sync_event_detector
    import sync_event_pkg::*;
#(
    parameter int CHANNELS = 4,
    parameter int STAGES   = 2,
    parameter int CNT_W    = 8
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic [CHANNELS-1:0]       i_async_in,
    input  logic [2*CHANNELS-1:0]     i_mode,
    input  logic [CHANNELS-1:0]       i_clr,
    output logic [CHANNELS-1:0]       o_sync_out,
    output logic [CHANNELS-1:0]       o_event_pulse,
    output logic [CHANNELS-1:0]       o_event_sticky,
    output logic [CHANNELS*CNT_W-1:0] o_event_cnt,
    output logic                      o_ready
);

    if (STAGES < 2) begin : g_bad_stages
        $fatal(1, "sync_event_detector: STAGES must be at least 2");
    end

    localparam int              WU_W    = clog2(STAGES + 2);
    localparam logic [WU_W-1:0] WU_DONE = WU_W'(STAGES + 1);

    logic [WU_W-1:0] r_wu_cnt;
    logic            w_ready;

    // Events stay masked until the chains have flushed the reset-time zeros,
    // so a level already high at reset never looks like a rising edge.
    assign w_ready = (r_wu_cnt == WU_DONE);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wu_cnt <= '0;
        end else if (!w_ready) begin
            r_wu_cnt <= r_wu_cnt + WU_W'(1);
        end
    end

    for (genvar i = 0; i < CHANNELS; i++) begin : g_ch
        sync_event_ch #(
            .STAGES (STAGES),
            .CNT_W  (CNT_W)
        ) u_ch (
            .clk      (clk),
            .rst_n    (rst_n),
            .i_async  (i_async_in[i]),
            .i_mode   (i_mode[2*i +: 2]),
            .i_clr    (i_clr[i]),
            .i_ready  (w_ready),
            .o_sync   (o_sync_out[i]),
            .o_pulse  (o_event_pulse[i]),
            .o_sticky (o_event_sticky[i]),
            .o_cnt    (o_event_cnt[CNT_W*i +: CNT_W])
        );
    end

    assign o_ready = w_ready;

endmodule

// File: tb/tb_sync_event_detector.sv
// tb_sync_event_detector: directed and randomized checks of sync_event_detector against a latency-rule model
module tb_sync_event_detector;

    localparam int CH = 4;
    localparam int ST = 2;
    localparam int CW = 3;
    localparam int CMAX = (1 << CW) - 1;

    logic              clk = 1'b0;
    logic              rst_n = 1'b1;
    logic [CH-1:0]     async_in = '0;
    logic [2*CH-1:0]   mode = '0;
    logic [CH-1:0]     clr = '0;
    logic [CH-1:0]     sync_out;
    logic [CH-1:0]     event_pulse;
    logic [CH-1:0]     event_sticky;
    logic [CH*CW-1:0]  event_cnt;
    logic              ready;

    int tests = 0;
    int fails = 0;

    // Model: every value captured at edge j (j = 1.. since reset release) is kept;
    // outputs follow from the fixed latencies of the chain.
    int            k;
    logic [CH-1:0] v[$];
    logic [CH-1:0] m_pulse;
    logic [CH-1:0] m_sticky;
    int            m_cnt[CH];
    int            seen[CH];

    sync_event_detector #(.CHANNELS(CH), .STAGES(ST), .CNT_W(CW)) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .i_async_in     (async_in),
        .i_mode         (mode),
        .i_clr          (clr),
        .o_sync_out     (sync_out),
        .o_event_pulse  (event_pulse),
        .o_event_sticky (event_sticky),
        .o_event_cnt    (event_cnt),
        .o_ready        (ready)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] want);
        tests++;
        assert (got === want) else begin
            fails++;
            $error("FAIL %s observed=%0h expected=%0h", tag, got, want);
        end
    endtask

    function automatic logic [CH-1:0] vat(input int j);
        return (j < 1) ? '0 : v[j-1];
    endfunction

    function automatic logic [CW-1:0] cnt_of(input int i);
        logic [CH*CW-1:0] t;
        t = event_cnt;
        return t[CW*i +: CW];
    endfunction

    task automatic step();
        logic [CH-1:0]    c_v, p_v, m_sync;
        logic [CH*CW-1:0] e_cnt;
        logic             m_ready;
        @(posedge clk);
        k++;
        v.push_back(async_in);
        c_v = vat(k - ST);
        p_v = vat(k - ST - 1);
        for (int i = 0; i < CH; i++) begin
            logic [1:0] md;
            logic       det, q;
            md  = mode[2*i +: 2];
            det = (md == 2'b01) ? (c_v[i] && !p_v[i]) :
                  (md == 2'b10) ? (!c_v[i] && p_v[i]) :
                  (md == 2'b11) ? (c_v[i] != p_v[i]) : 1'b0;
            q = det && (k >= ST + 2);
            m_pulse[i] = q;
            if (clr[i]) begin
                m_sticky[i] = q;
                m_cnt[i] = q ? 1 : 0;
            end else if (q) begin
                m_sticky[i] = 1'b1;
                if (m_cnt[i] < CMAX) m_cnt[i]++;
            end
        end
        m_sync  = vat(k - ST + 1);
        m_ready = (k >= ST + 1);
        for (int i = 0; i < CH; i++) e_cnt[CW*i +: CW] = CW'(m_cnt[i]);
        #1;
        chk("sync_out", 32'(sync_out), 32'(m_sync));
        chk("event_pulse", 32'(event_pulse), 32'(m_pulse));
        chk("event_sticky", 32'(event_sticky), 32'(m_sticky));
        chk("event_cnt", 32'(event_cnt), 32'(e_cnt));
        chk("ready", 32'(ready), 32'(m_ready));
        for (int i = 0; i < CH; i++) if (event_pulse[i]) seen[i]++;
    endtask

    task automatic reset_now();
        rst_n = 1'b0;
        #1;
        chk("rst_sync_out", 32'(sync_out), 32'h0);
        chk("rst_pulse", 32'(event_pulse), 32'h0);
        chk("rst_sticky", 32'(event_sticky), 32'h0);
        chk("rst_cnt", 32'(event_cnt), 32'h0);
        chk("rst_ready", 32'(ready), 32'h0);
        k = 0;
        v.delete();
        m_pulse = '0;
        m_sticky = '0;
        for (int i = 0; i < CH; i++) m_cnt[i] = 0;
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic clear_all();
        clr = '1;
        step();
        clr = '0;
        for (int i = 0; i < CH; i++) seen[i] = 0;
    endtask

    initial begin
        for (int i = 0; i < CH; i++) seen[i] = 0;

        // Warm-up mask: inputs high through reset, all modes detecting both edges
        async_in = 4'hF;
        mode = 8'hFF;
        #2;
        reset_now();
        for (int n = 1; n <= 6; n++) begin
            step();
            if (n == 2) chk("warm_sync", 32'(sync_out), 32'hF);
            if (n == 2) chk("warm_not_ready", 32'(ready), 32'h0);
            if (n == 3) chk("warm_ready", 32'(ready), 32'h1);
            chk("warm_no_pulse", 32'(event_pulse), 32'h0);
        end
        chk("warm_cnt", 32'(event_cnt), 32'h0);

        // Latency on channel 0, rising mode
        mode = 8'h55;
        async_in = '0;
        repeat (4) step();
        clear_all();
        async_in[0] = 1'b1;
        step();
        chk("lat_e0_sync", 32'(sync_out[0]), 32'h0);
        step();
        chk("lat_e1_sync", 32'(sync_out[0]), 32'h1);
        chk("lat_e1_pulse", 32'(event_pulse[0]), 32'h0);
        step();
        chk("lat_e2_pulse", 32'(event_pulse[0]), 32'h1);
        chk("lat_cnt", 32'(cnt_of(0)), 32'h1);
        chk("lat_sticky", 32'(event_sticky[0]), 32'h1);
        step();
        chk("lat_e3_pulse", 32'(event_pulse[0]), 32'h0);

        // Modes 00/01/10/11 on channels 0..3 with a 10-cycle wide pulse
        mode = 8'hE4;
        async_in = '0;
        repeat (4) step();
        clear_all();
        async_in = '1;
        repeat (10) step();
        async_in = '0;
        repeat (10) step();
        for (int i = 0; i < CH; i++) begin
            chk("mode_cnt", 32'(cnt_of(i)), (i == 0) ? 32'h0 : (i == 3) ? 32'h2 : 32'h1);
            chk("mode_pulses", 32'(seen[i]), (i == 0) ? 32'h0 : (i == 3) ? 32'h2 : 32'h1);
        end

        // Saturation on channel 1
        mode = 8'h0C;
        clear_all();
        for (int t = 0; t < 10; t++) begin
            async_in[1] = ~async_in[1];
            repeat (4) step();
        end
        chk("sat_pulses", 32'(seen[1]), 32'd10);
        chk("sat_cnt", 32'(cnt_of(1)), 32'd7);
        chk("sat_sticky", 32'(event_sticky[1]), 32'h1);

        // Clear colliding with an event on channel 2
        mode = 8'h30;
        clear_all();
        for (int t = 0; t < 5; t++) begin
            async_in[2] = ~async_in[2];
            repeat (4) step();
        end
        chk("coll_pre_cnt", 32'(cnt_of(2)), 32'd5);
        async_in[2] = ~async_in[2];
        step();
        step();
        clr[2] = 1'b1;
        step();
        chk("coll_cnt", 32'(cnt_of(2)), 32'd1);
        chk("coll_sticky", 32'(event_sticky[2]), 32'h1);
        step();
        chk("clr_cnt", 32'(cnt_of(2)), 32'd0);
        chk("clr_sticky", 32'(event_sticky[2]), 32'h0);
        clr = '0;

        // Reset mid-operation with an edge on channel 3 sitting in the first stage
        mode = 8'hFF;
        async_in = '0;
        repeat (4) step();
        async_in[1] = 1'b1;
        repeat (4) step();
        async_in[3] = 1'b1;
        step();
        reset_now();
        for (int n = 1; n <= 6; n++) begin
            step();
            chk("mid_no_pulse3", 32'(event_pulse[3]), 32'h0);
            if (n == 2) chk("mid_not_ready", 32'(ready), 32'h0);
            if (n == 3) chk("mid_ready", 32'(ready), 32'h1);
        end

        // Randomized traffic, with one reset in the middle
        for (int n = 0; n < 600; n++) begin
            if ($urandom_range(0, 3) == 0) async_in[$urandom_range(0, CH-1)] ^= 1'b1;
            if ($urandom_range(0, 31) == 0) mode = 8'($urandom);
            clr = ($urandom_range(0, 15) == 0) ? CH'($urandom) : '0;
            if (n == 300) reset_now();
            step();
        end
        clr = '0;

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/sync_event_detector.md
Name: sync_event_detector

Overview:
- Multi-channel successor to the team's toggle/pulse synchronizer.
- Each of CHANNELS asynchronous inputs passes through a STAGES-deep synchronizer into the clk domain.
- Each synchronized channel gets an edge detector with a per-channel mode, a one-cycle event pulse, a sticky flag and a saturating event counter.
- Sits at the clk-domain boundary of the status/interrupt logic, fed by signals from foreign clock domains.

Parameters:
- CHANNELS, 4: number of independent asynchronous inputs, 1..32.
- STAGES, 2: synchronizer flop depth, 2..4; values below 2 are a fatal elaboration error.
- CNT_W, 8: width of each per-channel event counter, 1..16.

Ports:
- clk  input  1: sole clock; every flop is on posedge clk.
- rst_n  input  1: reset, asynchronous assert, active-low; release is synchronous to clk, handled externally.
- async_in  input  CHANNELS: asynchronous levels, one per channel. Each bit must be glitch-free at source. No multi-bit coherence is implied.
- mode  input  2*CHANNELS: bits [2i+1:2i] select channel i detection. 00 = off, 01 = rising, 10 = falling, 11 = both edges. Quasi-static, synchronous to clk.
- clr  input  CHANNELS: synchronous per-channel clear of sticky flag and counter.
- sync_out  output  CHANNELS: synchronized level, s[STAGES-1] of each chain.
- event_pulse  output  CHANNELS: registered, single-cycle pulse per detected edge.
- event_sticky  output  CHANNELS: set by an event, cleared by clr.
- event_cnt  output  CHANNELS*CNT_W: channel i occupies bits [CNT_W*(i+1)-1 : CNT_W*i]. Saturating count.
- ready  output  1: high once warm-up has completed.

Behaviour:
- Reset (rst_n low): all synchronizer stages, history flops, event_pulse, event_sticky, event_cnt, the warm-up counter and ready go to 0 immediately. This is asynchronous.
- Reset mid-operation: same as above. In-flight edges are discarded.
- Synchronizer: s[0] <= async_in; s[k] <= s[k-1]; h <= s[STAGES-1].
- Latency from the first clk edge E0 that captures a change:
  - sync_out reflects the change after edge E(STAGES-1).
  - event_pulse is high for exactly the cycle after edge E(STAGES).
- Detection, combinational, per channel:
  - rise = s_last & ~h
  - fall = ~s_last & h
  - det is selected by mode: 00 gives 0, 01 gives rise, 10 gives fall, 11 gives rise|fall.
- event_pulse[i] <= det[i] & ready_int.
- Warm-up: after reset release, a counter runs STAGES+1 cycles. ready_int asserts when it reaches STAGES+1, and the counter then holds. Until then det is masked, so an input that is high during reset never produces a spurious rising event. sync_out is not masked. The ready port equals ready_int.
- Sticky/counter update, same edge as event_pulse asserts, driven by qualified det q:
  - clr=0, q=1: sticky <= 1; cnt <= cnt+1, saturating at 2^CNT_W-1 with no wrap.
  - clr=1, q=0: sticky <= 0; cnt <= 0.
  - clr=1, q=1: sticky <= 1; cnt <= 1. The event is never lost to a clear.
- Input toggling faster than 2 clk periods: edges may merge. A toggle pair narrower than one clk period may be missed entirely. This is documented, not detected.
- Mode change: takes effect on the next edge. No pulse is generated by the mode change itself.
- Channels are fully independent and may fire in the same cycle.

Decomposition:
- Package sync_event_pkg:
  - mode encodings MODE_OFF=2'b00, MODE_RISE=2'b01, MODE_FALL=2'b10, MODE_BOTH=2'b11.
  - function clog2 for warm-up counter width, which is clog2(STAGES+2).
- Sub-module sync_event_ch: one channel's synchronizer chain, history flop, detector, sticky flag and counter. Parameters are STAGES and CNT_W.
- Top level: generate loop over CHANNELS plus the shared warm-up counter. Top-level ready_int feeds each channel.

Test Plan:
- Warm-up mask: CHANNELS=4, STAGES=2. Hold async_in=4'b1111 through reset, release rst_n.
  - sync_out=1111 by 2nd edge.
  - ready rises after 3rd edge.
  - event_pulse stays 0; event_cnt all 0.
- Latency: mode ch0=01, rising edge on async_in[0] before edge E0.
  - sync_out[0]=1 after E1.
  - event_pulse[0] high exactly one cycle after E2.
  - event_cnt ch0=1, sticky[0]=1.
- Modes: apply a 0->1->0 pulse 10 cycles wide on each channel with modes 00/01/10/11.
  - Counts are 0/1/1/2 respectively.
  - Each pulse lasts one cycle.
- Saturation: CNT_W=3, ch1 mode 11, 10 toggles spaced 4 cycles.
  - event_cnt ch1 stops at 7.
  - event_pulse still fires 10 times.
- Clear collision: assert clr[2] in the same cycle ch2 det is 1 with cnt=5.
  - Next state cnt=1, sticky=1.
  - clr[2] alone next cycle gives cnt=0, sticky=0.
- Reset mid-operation: drop rst_n while ch3 has an edge in stage s[0].
  - All outputs 0 immediately.
  - After release with async_in[3] high, no event fires.
  - ready re-asserts after 3 cycles.
